fetch_pc_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_pc_ctrl_if.sv | 26 ++
 rtl/redirect_arb.sv | 56 +++++
 rtl/fetch_pc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch PC controller slice.
// Holds the fetch FSM states, redirect sources and the redirect overwrite rule.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'hBFC0_0380;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      HOLD
   } fetch_state_e;

   typedef enum logic [1:0] {
      NONE,
      BR,
      ERET,
      EX
   } redir_src_e;

   typedef struct packed {
      redir_src_e  src;
      logic [31:0] target;
   } redirect_t;

   // ex/eret always win; a branch may only displace nothing or an older branch
   function automatic logic redir_overrides(input redir_src_e incoming, input redir_src_e held);
      return (incoming == EX) || (incoming == ERET) ||
             ((incoming == BR) && ((held == NONE) || (held == BR)));
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// SRAM-like instruction fetch port: req/addr handshake followed by a data return.
interface fetch_pc_ctrl_if;

   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );

endinterface

// File: rtl/redirect_arb.sv
// Redirect priority select (ex > eret > br) and the pending-redirect register.
// eff_* is the redirect that would stand after merging this cycle's request into the pending one.
module redirect_arb
   import fetch_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        ex_valid,
   input  logic        eret_valid,
   input  logic [31:0] epc,
   input  logic        rec_redir,
   input  logic        clr_redir,
   output logic        redir_now,
   output logic [31:0] eff_target
);

   redirect_t cur;
   redirect_t eff;
   redirect_t pend_q;

   always_comb begin
      cur = '{src: NONE, target: '0};
      if (ex_valid) begin
         cur = '{src: EX, target: EXC_VEC};
      end else if (eret_valid) begin
         cur = '{src: ERET, target: epc + 32'd4};
      end else if (br_valid) begin
         cur = '{src: BR, target: br_target};
      end
   end

   always_comb begin
      eff = pend_q;
      if (redir_overrides(cur.src, pend_q.src)) begin
         eff = cur;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '{src: NONE, target: '0};
      end else if (rec_redir) begin
         pend_q <= eff;
      end else if (clr_redir) begin
         pend_q <= '{src: NONE, target: '0};
      end
   end

   assign redir_now  = (cur.src != NONE);
   assign eff_target = eff.target;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner and instruction-port sequencer with redirect/cancel and stall hold.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/discard counters.
module fetch_pc_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pc_wr,
   input  logic                   br_valid,
   input  logic [31:0]            br_target,
   input  logic                   ex_valid,
   input  logic                   eret_valid,
   input  logic [31:0]            epc,
   fetch_pc_ctrl_if.master        imem,
   output logic                   if_valid,
   output logic [31:0]            if_pc,
   output logic [31:0]            if_inst,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]            perf_redirects,
   output logic [31:0]            perf_discards,
`endif
   output logic [31:0]            pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q;
   logic         cancel_q, cancel_d;
   logic         hold_load;
   logic         rec_redir;
   logic         clr_redir;
   logic         redir_now;
   logic [31:0]  eff_target;

   redirect_arb #(
      .EXC_VEC (EXC_VEC)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .ex_valid   (ex_valid),
      .eret_valid (eret_valid),
      .epc        (epc),
      .rec_redir  (rec_redir),
      .clr_redir  (clr_redir),
      .redir_now  (redir_now),
      .eff_target (eff_target)
   );

   // clr_redir marks every cycle in which a redirect target is loaded into pc
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      cancel_d       = cancel_q;
      hold_load      = 1'b0;
      rec_redir      = 1'b0;
      clr_redir      = 1'b0;
      imem.inst_req  = 1'b0;
      if_valid       = 1'b0;
      if_inst        = hold_q;
      unique case (state_q)
         IDLE: begin
            state_d = ADDR;
            if (redir_now) begin
               pc_d      = eff_target;
               clr_redir = 1'b1;
            end
         end
         ADDR: begin
            imem.inst_req = 1'b1;
            if (redir_now) begin
               rec_redir = 1'b1;
               cancel_d  = 1'b1;
            end
            if (imem.inst_addr_ok) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (imem.inst_data_ok) begin
               if (cancel_q || redir_now) begin
                  pc_d      = eff_target;
                  clr_redir = 1'b1;
                  cancel_d  = 1'b0;
                  state_d   = ADDR;
               end else begin
                  if_valid = 1'b1;
                  if_inst  = imem.inst_rdata;
                  if (pc_wr) begin
                     pc_d    = pc_q + 32'd4;
                     state_d = ADDR;
                  end else begin
                     hold_load = 1'b1;
                     state_d   = HOLD;
                  end
               end
            end else if (redir_now) begin
               rec_redir = 1'b1;
               cancel_d  = 1'b1;
            end
         end
         HOLD: begin
            if (redir_now) begin
               pc_d      = eff_target;
               clr_redir = 1'b1;
               state_d   = ADDR;
            end else begin
               if_valid = 1'b1;
               if (pc_wr) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = ADDR;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         cancel_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cancel_q <= cancel_d;
         if (hold_load) begin
            hold_q <= imem.inst_rdata;
         end
      end
   end

   assign imem.inst_addr = pc_q;
   assign if_pc          = pc_q;
   assign pc             = pc_q;

`ifdef FETCH_PERF_CNT_EN
   logic discard;
   assign discard = (state_q == DATA) && clr_redir;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_redirects <= '0;
         perf_discards  <= '0;
      end else begin
         if (clr_redir && (perf_redirects != '1)) begin
            perf_redirects <= perf_redirects + 32'd1;
         end
         if (discard && (perf_discards != '1)) begin
            perf_discards <= perf_discards + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, reset-mid-fetch sequence, then
// randomized traffic against a transaction-level reference model.
module tb_fetch_pc_ctrl;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;
   localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

   logic        clk;
   logic        rst;
   logic        pc_wr;
   logic        br_valid;
   logic [31:0] br_target;
   logic        ex_valid;
   logic        eret_valid;
   logic [31:0] epc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_redirects;
   logic [31:0] perf_discards;
`endif

   fetch_pc_ctrl_if imem();

   fetch_pc_ctrl #(
      .RESET_PC (RST_PC),
      .EXC_VEC  (EXC_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_wr          (pc_wr),
      .br_valid       (br_valid),
      .br_target      (br_target),
      .ex_valid       (ex_valid),
      .eret_valid     (eret_valid),
      .epc            (epc),
      .imem           (imem),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
`ifdef FETCH_PERF_CNT_EN
      .perf_redirects (perf_redirects),
      .perf_discards  (perf_discards),
`endif
      .pc             (pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic a, input logic d, input logic w,
                         input logic [31:0] rd, input logic [2:0] redir, input logic [31:0] tgt);
      rst                = r;
      imem.inst_addr_ok  = a;
      imem.inst_data_ok  = d;
      imem.inst_rdata    = rd;
      pc_wr              = w;
      ex_valid           = redir[2];
      eret_valid         = redir[1];
      br_valid           = redir[0];
      br_target          = tgt;
      epc                = tgt;
   endtask

   typedef struct {
      logic        a, d, w;
      logic [31:0] rd;
      logic [2:0]  redir;   // {ex, eret, br}
      logic [31:0] tgt;     // br_target and epc
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_ifpc, e_inst, e_pc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic a, d, w, input logic [31:0] rd, input logic [2:0] redir,
                               input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                               input logic e_ifv, input logic [31:0] e_ifpc, e_inst, e_pc);
      vec_t v;
      v.a = a; v.d = d; v.w = w; v.rd = rd; v.redir = redir; v.tgt = tgt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv;
      v.e_ifpc = e_ifpc; v.e_inst = e_inst; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_ifv, input logic [31:0] e_ifpc, e_inst, e_pc);
      chk({tag, ".inst_req"}, {31'd0, imem.inst_req}, {31'd0, e_req});
      if (e_req) chk({tag, ".inst_addr"}, imem.inst_addr, e_addr);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e_ifv});
      if (e_ifv) begin
         chk({tag, ".if_pc"}, if_pc, e_ifpc);
         chk({tag, ".if_inst"}, if_inst, e_inst);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] m_pc, m_held, m_ptgt, mem_addr;
   logic        m_started, m_wait, m_hold, mem_busy;
   int          m_prank;
   int          m_nredir, m_ndisc;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_started = 0; m_wait = 0; m_hold = 0; m_prank = 0; m_ptgt = '0;
      m_held = '0; mem_busy = 0; mem_addr = '0; m_nredir = 0; m_ndisc = 0;
   endtask

   initial begin
      int          cur_rank, mrank;
      logic [31:0] cur_tgt, mtgt, x_inst;
      logic        x_req, x_ifv;
      logic [31:0] rtgt;

      set_in(1'b1, 0, 0, 1, '0, 3'b000, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);

      // directed table: steady fetch, br cancel, ex+br priority, stall hold, eret in HOLD, wrap
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 0,32'h0,0,32'h0,32'h0, RST_PC));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00000,0,32'h0,32'h0, 32'hBFC00000));
      tbl.push_back(mk(0,1,1,32'h11111111,3'b000,32'h0, 0,32'h0,1,32'hBFC00000,32'h11111111, 32'hBFC00000));
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00004,0,32'h0,32'h0, 32'hBFC00004));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00004,0,32'h0,32'h0, 32'hBFC00004));
      tbl.push_back(mk(0,1,1,32'h22222222,3'b000,32'h0, 0,32'h0,1,32'hBFC00004,32'h22222222, 32'hBFC00004));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00008,0,32'h0,32'h0, 32'hBFC00008));
      tbl.push_back(mk(0,0,1,32'h0,3'b001,32'hBFC00100, 0,32'h0,0,32'h0,32'h0, 32'hBFC00008));
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 0,32'h0,0,32'h0,32'h0, 32'hBFC00008));
      tbl.push_back(mk(0,1,1,32'h33333333,3'b000,32'h0, 0,32'h0,0,32'h0,32'h0, 32'hBFC00008));
      tbl.push_back(mk(0,0,1,32'h0,3'b101,32'hBFC00200, 1,32'hBFC00100,0,32'h0,32'h0, 32'hBFC00100));
      tbl.push_back(mk(1,0,1,32'h0,3'b001,32'hBFC00300, 1,32'hBFC00100,0,32'h0,32'h0, 32'hBFC00100));
      tbl.push_back(mk(0,1,1,32'h44444444,3'b000,32'h0, 0,32'h0,0,32'h0,32'h0, 32'hBFC00100));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00380,0,32'h0,32'h0, 32'hBFC00380));
      tbl.push_back(mk(0,1,0,32'h55555555,3'b000,32'h0, 0,32'h0,1,32'hBFC00380,32'h55555555, 32'hBFC00380));
      tbl.push_back(mk(0,0,0,32'hDEADBEEF,3'b000,32'h0, 0,32'h0,1,32'hBFC00380,32'h55555555, 32'hBFC00380));
      tbl.push_back(mk(0,0,0,32'h0,3'b000,32'h0, 0,32'h0,1,32'hBFC00380,32'h55555555, 32'hBFC00380));
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 0,32'h0,1,32'hBFC00380,32'h55555555, 32'hBFC00380));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hBFC00384,0,32'h0,32'h0, 32'hBFC00384));
      tbl.push_back(mk(0,1,0,32'h66666666,3'b000,32'h0, 0,32'h0,1,32'hBFC00384,32'h66666666, 32'hBFC00384));
      tbl.push_back(mk(0,0,1,32'h0,3'b010,32'h80001000, 0,32'h0,0,32'h0,32'h0, 32'hBFC00384));
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 1,32'h80001004,0,32'h0,32'h0, 32'h80001004));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'h80001004,0,32'h0,32'h0, 32'h80001004));
      tbl.push_back(mk(0,1,1,32'h77777777,3'b001,32'hFFFFFFFC, 0,32'h0,0,32'h0,32'h0, 32'h80001004));
      tbl.push_back(mk(1,0,1,32'h0,3'b000,32'h0, 1,32'hFFFFFFFC,0,32'h0,32'h0, 32'hFFFFFFFC));
      tbl.push_back(mk(0,1,1,32'h88888888,3'b000,32'h0, 0,32'h0,1,32'hFFFFFFFC,32'h88888888, 32'hFFFFFFFC));
      tbl.push_back(mk(0,0,1,32'h0,3'b000,32'h0, 1,32'h00000000,0,32'h0,32'h0, 32'h00000000));

      foreach (tbl[i]) begin
         set_in(1'b0, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].rd, tbl[i].redir, tbl[i].tgt);
         #2;
         check_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ifv,
                    tbl[i].e_ifpc, tbl[i].e_inst, tbl[i].e_pc);
         @(negedge clk);
      end

      // reset while waiting for data, then a redirect taken straight from IDLE
      set_in(1'b0, 1, 0, 1, '0, 3'b000, '0);
      #2 check_outs("rstseq.addr", 1'b1, 32'h0, 1'b0, '0, '0, 32'h0);
      @(negedge clk);
      set_in(1'b1, 0, 0, 1, '0, 3'b000, '0);
      #2 check_outs("rstseq.data", 1'b0, '0, 1'b0, '0, '0, 32'h0);
      @(negedge clk);
      set_in(1'b0, 0, 0, 1, '0, 3'b001, 32'h0040_0000);
      #2 check_outs("rstseq.idle", 1'b0, '0, 1'b0, '0, '0, RST_PC);
      @(negedge clk);
      set_in(1'b0, 0, 0, 1, '0, 3'b000, '0);
      #2 check_outs("rstseq.redir", 1'b1, 32'h0040_0000, 1'b0, '0, '0, 32'h0040_0000);
      @(negedge clk);

      // randomized traffic against the reference model
      set_in(1'b1, 0, 0, 1, '0, 3'b000, '0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 4000; c++) begin
         rtgt = $urandom;
         if ($urandom_range(0, 3) != 0) rtgt[1:0] = 2'b00;
         x_req = m_started && !m_wait && !m_hold;
         rst               = ($urandom_range(0, 299) == 0);
         ex_valid          = ($urandom_range(0, 29) == 0);
         eret_valid        = ($urandom_range(0, 24) == 0);
         br_valid          = ($urandom_range(0, 7) == 0);
         br_target         = rtgt;
         epc               = $urandom;
         pc_wr             = ($urandom_range(0, 3) != 0);
         imem.inst_addr_ok = x_req && !mem_busy && ($urandom_range(0, 1) == 1);
         imem.inst_data_ok = mem_busy && ($urandom_range(0, 2) == 0);
         imem.inst_rdata   = mem_busy ? inst_of(mem_addr) : $urandom;

         cur_rank = ex_valid ? 3 : eret_valid ? 2 : br_valid ? 1 : 0;
         cur_tgt  = ex_valid ? EXC_PC : eret_valid ? epc + 32'd4 : br_target;
         if (cur_rank >= 2 || (cur_rank == 1 && m_prank <= 1)) begin
            mrank = cur_rank; mtgt = cur_tgt;
         end else begin
            mrank = m_prank; mtgt = m_ptgt;
         end
         x_ifv  = m_hold ? (cur_rank == 0)
                         : (m_wait && imem.inst_data_ok && m_prank == 0 && cur_rank == 0);
         x_inst = m_hold ? m_held : imem.inst_rdata;
         #2;
         check_outs($sformatf("rand%0d", c), x_req, m_pc, x_ifv, m_pc, x_inst, m_pc);
         @(posedge clk);

         if (rst) begin
            model_reset();
         end else begin
            if (imem.inst_data_ok) mem_busy = 0;
            if (imem.inst_addr_ok) begin
               mem_busy = 1;
               mem_addr = m_pc;
            end
            if (!m_started) begin
               m_started = 1;
               if (cur_rank != 0) begin
                  m_pc = mtgt; m_nredir++;
               end
            end else if (m_hold) begin
               if (cur_rank != 0) begin
                  m_pc = cur_tgt; m_hold = 0; m_nredir++;
               end else if (pc_wr) begin
                  m_pc = m_pc + 32'd4; m_hold = 0;
               end
            end else if (m_wait) begin
               if (imem.inst_data_ok) begin
                  m_wait = 0;
                  if (mrank != 0) begin
                     m_pc = mtgt; m_prank = 0; m_nredir++; m_ndisc++;
                  end else if (pc_wr) begin
                     m_pc = m_pc + 32'd4;
                  end else begin
                     m_held = imem.inst_rdata; m_hold = 1;
                  end
               end else if (cur_rank != 0) begin
                  m_prank = mrank; m_ptgt = mtgt;
               end
            end else begin
               if (cur_rank != 0) begin
                  m_prank = mrank; m_ptgt = mtgt;
               end
               if (imem.inst_addr_ok) m_wait = 1;
            end
         end
         @(negedge clk);
      end

`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirects", perf_redirects, m_nredir);
      chk("perf_discards", perf_discards, m_ndisc);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
